// File: rtl/up_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : up_sequencer_if
//  Description : Control bundle between the uP sequencer and the rest of the
//                4-bit datapath (ROM/fetch path, ALU, accumulator, RAM, I/O).
//                master = sequencer side, slave = datapath side.
//  Signals     : run, rom_hi[3:0], instr[3:0], alu_c, alu_z   (to sequencer)
//                state[1:0], phase, pc_inc, pc_load, fetch_en, addr_lo_en,
//                acc_en, alu_sel[2:0], oe_oprnd, oe_in, oe_alu, oe_acc,
//                ram_cs, ram_we, out_en, c_flag, z_flag         (from sequencer)
//  Revision    : 1.0  initial release
// ============================================================================
interface up_sequencer_if;
    // Inputs to the sequencer
    logic       run;
    logic [3:0] rom_hi;
    logic [3:0] instr;
    logic       alu_c;
    logic       alu_z;

    // Outputs of the sequencer
    logic [1:0] state;
    logic       phase;
    logic       pc_inc;
    logic       pc_load;
    logic       fetch_en;
    logic       addr_lo_en;
    logic       acc_en;
    logic [2:0] alu_sel;
    logic       oe_oprnd;
    logic       oe_in;
    logic       oe_alu;
    logic       oe_acc;
    logic       ram_cs;
    logic       ram_we;
    logic       out_en;
    logic       c_flag;
    logic       z_flag;

    modport master (
        input  run, rom_hi, instr, alu_c, alu_z,
        output state, phase, pc_inc, pc_load, fetch_en, addr_lo_en, acc_en,
               alu_sel, oe_oprnd, oe_in, oe_alu, oe_acc, ram_cs, ram_we,
               out_en, c_flag, z_flag
    );

    modport slave (
        output run, rom_hi, instr, alu_c, alu_z,
        input  state, phase, pc_inc, pc_load, fetch_en, addr_lo_en, acc_en,
               alu_sel, oe_oprnd, oe_in, oe_alu, oe_acc, ram_cs, ram_we,
               out_en, c_flag, z_flag
    );
endinterface
`default_nettype wire

// File: rtl/up_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : up_sequencer
//  Description : Multicycle FETCH / ADDR / EXEC control sequencer for the
//                4-bit microprocessor. Drives PC, fetch registers,
//                accumulator, ALU select, bus enables and RAM strobes, and
//                holds the carry / zero flags.
//  Ports       : clock   - system clock, rising edge active
//                reset   - asynchronous, active-low reset
//                bus     - up_sequencer_if.master control bundle
//                          (run, rom_hi, instr, alu_c, alu_z in;
//                           state, phase, strobes, alu_sel, flags out)
//  Revision    : 1.0  initial release
// ============================================================================
module up_sequencer (
    input  wire            clock,
    input  wire            reset,
    up_sequencer_if.master bus
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] c_FETCH   = 2'b00;
    localparam logic [1:0] c_ADDR    = 2'b01;
    localparam logic [1:0] c_EXEC    = 2'b10;
    localparam logic [1:0] c_ILLEGAL = 2'b11;

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [3:0] c_OP_JC    = 4'h0;
    localparam logic [3:0] c_OP_JNC   = 4'h1;
    localparam logic [3:0] c_OP_CMPI  = 4'h2;
    localparam logic [3:0] c_OP_CMPM  = 4'h3;
    localparam logic [3:0] c_OP_LIT   = 4'h4;
    localparam logic [3:0] c_OP_IN    = 4'h5;
    localparam logic [3:0] c_OP_LD    = 4'h6;
    localparam logic [3:0] c_OP_ST    = 4'h7;
    localparam logic [3:0] c_OP_JZ    = 4'h8;
    localparam logic [3:0] c_OP_JNZ   = 4'h9;
    localparam logic [3:0] c_OP_ADDI  = 4'hA;
    localparam logic [3:0] c_OP_ADDM  = 4'hB;
    localparam logic [3:0] c_OP_JMP   = 4'hC;
    localparam logic [3:0] c_OP_OUT   = 4'hD;
    localparam logic [3:0] c_OP_NANDI = 4'hE;
    localparam logic [3:0] c_OP_NANDM = 4'hF;

    // ------------------------------------------------------------------
    // ALU function selects
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ALU_PASS_A = 3'b000;
    localparam logic [2:0] c_ALU_PASS_B = 3'b010;
    localparam logic [2:0] c_ALU_NAND   = 3'b100;
    localparam logic [2:0] c_ALU_SUB    = 3'b001;
    localparam logic [2:0] c_ALU_ADD    = 3'b011;

    // ------------------------------------------------------------------
    // Registers and decode wires
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic       r_c_flag;
    logic       r_z_flag;

    logic [1:0] w_next_state;
    logic       w_fetch_two_byte;
    logic       w_jump_taken;
    logic       w_flag_we;

    logic       w_pc_inc;
    logic       w_pc_load;
    logic       w_fetch_en;
    logic       w_addr_lo_en;
    logic       w_acc_en;
    logic [2:0] w_alu_sel;
    logic       w_oe_oprnd;
    logic       w_oe_in;
    logic       w_oe_alu;
    logic       w_oe_acc;
    logic       w_ram_cs;
    logic       w_ram_we;
    logic       w_out_en;

    // Opcodes that carry a second byte (jump target low / RAM address).
    function automatic logic f_two_byte(input logic [3:0] op);
        logic v;
        case (op)
            c_OP_JC, c_OP_JNC, c_OP_JZ, c_OP_JNZ, c_OP_JMP,
            c_OP_CMPM, c_OP_ADDM, c_OP_NANDM,
            c_OP_LD, c_OP_ST:  v = 1'b1;
            default:           v = 1'b0;
        endcase
        return v;
    endfunction

    // The length decision is taken from the raw ROM nibble because instr is
    // only latched at the end of FETCH.
    assign w_fetch_two_byte = f_two_byte(bus.rom_hi);

    // Jump conditions look at the flags as registered before this EXEC.
    always_comb begin
        w_jump_taken = 1'b0;
        case (bus.instr)
            c_OP_JMP: w_jump_taken = 1'b1;
            c_OP_JC:  w_jump_taken = r_c_flag;
            c_OP_JNC: w_jump_taken = ~r_c_flag;
            c_OP_JZ:  w_jump_taken = r_z_flag;
            c_OP_JNZ: w_jump_taken = ~r_z_flag;
            default:  w_jump_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = c_FETCH;
        case (r_state)
            c_FETCH: begin
                if (bus.run) begin
                    w_next_state = w_fetch_two_byte ? c_ADDR : c_EXEC;
                end else begin
                    w_next_state = c_FETCH;
                end
            end
            c_ADDR:    w_next_state = c_EXEC;
            c_EXEC:    w_next_state = c_FETCH;
            c_ILLEGAL: w_next_state = c_FETCH;
            default:   w_next_state = c_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Everything is forced low while reset is asserted so an
    // instruction caught mid-flight cannot leave a stray strobe behind.
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_inc     = 1'b0;
        w_pc_load    = 1'b0;
        w_fetch_en   = 1'b0;
        w_addr_lo_en = 1'b0;
        w_acc_en     = 1'b0;
        w_alu_sel    = c_ALU_PASS_A;
        w_oe_oprnd   = 1'b0;
        w_oe_in      = 1'b0;
        w_oe_alu     = 1'b0;
        w_oe_acc     = 1'b0;
        w_ram_cs     = 1'b0;
        w_ram_we     = 1'b0;
        w_out_en     = 1'b0;
        w_flag_we    = 1'b0;

        if (reset) begin
            case (r_state)
                c_FETCH: begin
                    if (bus.run) begin
                        w_fetch_en = 1'b1;
                        w_pc_inc   = 1'b1;
                    end
                end

                c_ADDR: begin
                    w_addr_lo_en = 1'b1;
                    w_pc_inc     = 1'b1;
                end

                c_EXEC: begin
                    case (bus.instr)
                        c_OP_LIT: begin
                            w_oe_oprnd = 1'b1;
                            w_alu_sel  = c_ALU_PASS_B;
                            w_acc_en   = 1'b1;
                        end
                        c_OP_IN: begin
                            w_oe_in   = 1'b1;
                            w_alu_sel = c_ALU_PASS_B;
                            w_acc_en  = 1'b1;
                        end
                        c_OP_LD: begin
                            w_ram_cs  = 1'b1;
                            w_alu_sel = c_ALU_PASS_B;
                            w_acc_en  = 1'b1;
                        end
                        c_OP_ST: begin
                            w_oe_acc = 1'b1;
                            w_ram_cs = 1'b1;
                            w_ram_we = 1'b1;
                        end
                        c_OP_ADDI: begin
                            w_oe_oprnd = 1'b1;
                            w_alu_sel  = c_ALU_ADD;
                            w_acc_en   = 1'b1;
                            w_flag_we  = 1'b1;
                        end
                        c_OP_ADDM: begin
                            w_ram_cs  = 1'b1;
                            w_alu_sel = c_ALU_ADD;
                            w_acc_en  = 1'b1;
                            w_flag_we = 1'b1;
                        end
                        // Compare is a subtract whose result is discarded.
                        c_OP_CMPI: begin
                            w_oe_oprnd = 1'b1;
                            w_alu_sel  = c_ALU_SUB;
                            w_flag_we  = 1'b1;
                        end
                        c_OP_CMPM: begin
                            w_ram_cs  = 1'b1;
                            w_alu_sel = c_ALU_SUB;
                            w_flag_we = 1'b1;
                        end
                        c_OP_NANDI: begin
                            w_oe_oprnd = 1'b1;
                            w_alu_sel  = c_ALU_NAND;
                            w_acc_en   = 1'b1;
                        end
                        c_OP_NANDM: begin
                            w_ram_cs  = 1'b1;
                            w_alu_sel = c_ALU_NAND;
                            w_acc_en  = 1'b1;
                        end
                        c_OP_OUT: begin
                            w_oe_acc = 1'b1;
                            w_out_en = 1'b1;
                        end
                        // Jumps: only PC activity, and only when taken.
                        default: begin
                            w_pc_load = w_jump_taken;
                        end
                    endcase
                end

                // Unused encoding: quiet, like FETCH with run low.
                default: begin
                    w_pc_inc = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= c_FETCH;
            r_c_flag <= 1'b0;
            r_z_flag <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_flag_we) begin
                r_c_flag <= bus.alu_c;
                r_z_flag <= bus.alu_z;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.state      = r_state;
    assign bus.phase      = (r_state != c_FETCH);
    assign bus.pc_inc     = w_pc_inc;
    assign bus.pc_load    = w_pc_load;
    assign bus.fetch_en   = w_fetch_en;
    assign bus.addr_lo_en = w_addr_lo_en;
    assign bus.acc_en     = w_acc_en;
    assign bus.alu_sel    = w_alu_sel;
    assign bus.oe_oprnd   = w_oe_oprnd;
    assign bus.oe_in      = w_oe_in;
    assign bus.oe_alu     = w_oe_alu;
    assign bus.oe_acc     = w_oe_acc;
    assign bus.ram_cs     = w_ram_cs;
    assign bus.ram_we     = w_ram_we;
    assign bus.out_en     = w_out_en;
    assign bus.c_flag     = r_c_flag;
    assign bus.z_flag     = r_z_flag;

endmodule
`default_nettype wire

// File: tb/tb_up_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_up_sequencer
//  Description : Scoreboard bench for up_sequencer. A driver issues whole
//                instructions, a mnemonic-level model pushes the expected
//                per-cycle control vector, a monitor pops and compares on the
//                falling edge. A small PC emulator follows pc_inc/pc_load.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_up_sequencer;

    logic clock = 1'b0;
    logic reset;

    up_sequencer_if bus ();

    up_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] state;
        logic       phase;
        logic       pc_inc;
        logic       pc_load;
        logic       fetch_en;
        logic       addr_lo_en;
        logic       acc_en;
        logic [2:0] alu_sel;
        logic       oe_oprnd;
        logic       oe_in;
        logic       oe_alu;
        logic       oe_acc;
        logic       ram_cs;
        logic       ram_we;
        logic       out_en;
        logic       c_flag;
        logic       z_flag;
    } ctl_t;

    typedef struct {
        ctl_t  ctl;
        string tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Architectural model state
    logic        m_c, m_z;
    logic [11:0] exp_pc;
    // PC emulator driven by the DUT strobes
    logic [11:0] sim_pc;
    logic [11:0] jump_target;

    string mnem [16] = '{"JC", "JNC", "CMPI", "CMPM", "LIT", "IN", "LD", "ST",
                         "JZ", "JNZ", "ADDI", "ADDM", "JMP", "OUT", "NANDI", "NANDM"};

    // ------------------------------------------------------------------
    // Mnemonic-level reference model
    // ------------------------------------------------------------------
    function automatic logic is_jump(string mn);
        return mn.substr(0, 0) == "J";
    endfunction

    function automatic int instr_len(string mn);
        // jumps carry a target byte; LD/ST and the *M forms carry a RAM address
        if (is_jump(mn) || mn == "LD" || mn == "ST" ||
            mn.substr(mn.len() - 1, mn.len() - 1) == "M")
            return 2;
        return 1;
    endfunction

    function automatic logic writes_flags(string mn);
        return (mn.substr(0, 2) == "ADD") || (mn.substr(0, 2) == "CMP");
    endfunction

    function automatic logic taken(string mn, logic c, logic z);
        case (mn)
            "JMP":   return 1'b1;
            "JC":    return c;
            "JNC":   return !c;
            "JZ":    return z;
            "JNZ":   return !z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctl_t quiet(logic [1:0] st, logic c, logic z);
        ctl_t r = '0;
        r.state  = st;
        r.phase  = (st != 2'b00);
        r.c_flag = c;
        r.z_flag = z;
        return r;
    endfunction

    function automatic ctl_t exec_ctl(string mn, logic c, logic z);
        ctl_t r = quiet(2'b10, c, z);
        case (mn)
            "LIT":   begin r.oe_oprnd = 1; r.alu_sel = 3'b010; r.acc_en = 1; end
            "IN":    begin r.oe_in    = 1; r.alu_sel = 3'b010; r.acc_en = 1; end
            "LD":    begin r.ram_cs   = 1; r.alu_sel = 3'b010; r.acc_en = 1; end
            "ST":    begin r.oe_acc   = 1; r.ram_cs  = 1;      r.ram_we = 1; end
            "ADDI":  begin r.oe_oprnd = 1; r.alu_sel = 3'b011; r.acc_en = 1; end
            "ADDM":  begin r.ram_cs   = 1; r.alu_sel = 3'b011; r.acc_en = 1; end
            "CMPI":  begin r.oe_oprnd = 1; r.alu_sel = 3'b001; end
            "CMPM":  begin r.ram_cs   = 1; r.alu_sel = 3'b001; end
            "NANDI": begin r.oe_oprnd = 1; r.alu_sel = 3'b100; r.acc_en = 1; end
            "NANDM": begin r.ram_cs   = 1; r.alu_sel = 3'b100; r.acc_en = 1; end
            "OUT":   begin r.oe_acc   = 1; r.out_en  = 1; end
            default: r.pc_load = taken(mn, c, z);
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // PC emulator (what the datapath would do with the strobes)
    // ------------------------------------------------------------------
    always @(posedge clock or negedge reset) begin
        if (!reset)
            sim_pc <= 12'h000;
        else if (bus.pc_load)
            sim_pc <= jump_target;
        else if (bus.pc_inc)
            sim_pc <= sim_pc + 12'h001;
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    function automatic ctl_t sample();
        ctl_t a;
        a.state      = bus.state;
        a.phase      = bus.phase;
        a.pc_inc     = bus.pc_inc;
        a.pc_load    = bus.pc_load;
        a.fetch_en   = bus.fetch_en;
        a.addr_lo_en = bus.addr_lo_en;
        a.acc_en     = bus.acc_en;
        a.alu_sel    = bus.alu_sel;
        a.oe_oprnd   = bus.oe_oprnd;
        a.oe_in      = bus.oe_in;
        a.oe_alu     = bus.oe_alu;
        a.oe_acc     = bus.oe_acc;
        a.ram_cs     = bus.ram_cs;
        a.ram_we     = bus.ram_we;
        a.out_en     = bus.out_en;
        a.c_flag     = bus.c_flag;
        a.z_flag     = bus.z_flag;
        return a;
    endfunction

    always @(negedge clock) begin
        ctl_t a;
        exp_t e;
        a = sample();
        checks++;
        if ($countones({a.oe_oprnd, a.oe_in, a.oe_alu, a.oe_acc}) > 1) begin
            failures++;
            $display("FAIL oe_onehot actual=%b required=at most one high",
                     {a.oe_oprnd, a.oe_in, a.oe_alu, a.oe_acc});
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (a !== e.ctl) begin
                failures++;
                $display("FAIL ctl[%s] actual=%h required=%h", e.tag, a, e.ctl);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void push(ctl_t c, string tag);
        exp_t e;
        e.ctl = c;
        e.tag = tag;
        sb_q.push_back(e);
    endfunction

    task automatic check_now(string name, ctl_t act, ctl_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            bus.run    = 1'b0;
            bus.rom_hi = 4'($urandom);
            bus.instr  = 4'($urandom);
            bus.alu_c  = 1'($urandom);
            bus.alu_z  = 1'($urandom);
            push(quiet(2'b00, m_c, m_z), "idle");
            tick();
        end
    endtask

    task automatic do_instr(input logic [3:0] op, input logic run_mid,
                            input logic ac, input logic az, input logic [11:0] tgt);
        string       mn;
        int          len;
        logic [11:0] pc0;
        logic        tk;
        ctl_t        e;
        mn  = mnem[op];
        len = instr_len(mn);
        pc0 = exp_pc;

        // FETCH
        bus.run     = 1'b1;
        bus.rom_hi  = op;
        bus.instr   = 4'($urandom);
        bus.alu_c   = 1'($urandom);
        bus.alu_z   = 1'($urandom);
        jump_target = tgt;
        e = quiet(2'b00, m_c, m_z);
        e.fetch_en = 1'b1;
        e.pc_inc   = 1'b1;
        push(e, {mn, ":fetch"});
        tick();

        bus.instr  = op;
        bus.run    = run_mid;
        bus.rom_hi = 4'($urandom);

        // ADDR
        if (len == 2) begin
            e = quiet(2'b01, m_c, m_z);
            e.addr_lo_en = 1'b1;
            e.pc_inc     = 1'b1;
            push(e, {mn, ":addr"});
            tick();
            bus.rom_hi = 4'($urandom);
        end

        // EXEC
        bus.alu_c = ac;
        bus.alu_z = az;
        push(exec_ctl(mn, m_c, m_z), {mn, ":exec"});
        tk = taken(mn, m_c, m_z);
        tick();

        if (writes_flags(mn)) begin
            m_c = ac;
            m_z = az;
        end
        exp_pc = tk ? tgt : pc0 + 12'(len);
        checks++;
        if (sim_pc !== exp_pc) begin
            failures++;
            $display("FAIL pc[%s] actual=%h required=%h", mn, sim_pc, exp_pc);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        ctl_t zero_ctl;
        reset      = 1'b0;
        bus.run    = 1'b1;
        bus.rom_hi = 4'h4;
        bus.instr  = 4'h0;
        bus.alu_c  = 1'b0;
        bus.alu_z  = 1'b0;
        jump_target = 12'h000;
        m_c    = 1'b0;
        m_z    = 1'b0;
        exp_pc = 12'h000;
        tick();

        // Held in reset with run high: FETCH, no strobes, flags clear
        for (int i = 0; i < 3; i++) begin
            bus.rom_hi = 4'($urandom);
            push(quiet(2'b00, 1'b0, 1'b0), "reset");
            tick();
        end

        // Release with run low: parks in FETCH
        reset = 1'b1;
        idle(10);

        // LIT 5, then JMP 0x123
        do_instr(4'h4, 1'b1, 1'b0, 1'b0, 12'h000);
        do_instr(4'hC, 1'b1, 1'b0, 1'b0, 12'h123);

        // LIT 9; CMPI 9 (zero); JZ 0x010 taken
        do_instr(4'h4, 1'b1, 1'b0, 1'b0, 12'h000);
        do_instr(4'h2, 1'b1, 1'b0, 1'b1, 12'h000);
        do_instr(4'h8, 1'b1, 1'b0, 1'b0, 12'h010);
        // Same with non-zero compare: JZ falls through
        do_instr(4'h4, 1'b1, 1'b0, 1'b0, 12'h000);
        do_instr(4'h2, 1'b1, 1'b0, 1'b0, 12'h000);
        do_instr(4'h8, 1'b1, 1'b0, 1'b0, 12'h010);

        // ST and LD
        do_instr(4'h7, 1'b1, 1'b0, 1'b0, 12'h000);
        do_instr(4'h6, 1'b1, 1'b0, 1'b0, 12'h000);

        // run drops during a JMP: the jump completes, then FETCH holds
        do_instr(4'hC, 1'b0, 1'b0, 1'b0, 12'h3A5);
        idle(4);

        // Reset pulse during EXEC of ADDI with carry out
        bus.run    = 1'b1;
        bus.rom_hi = 4'hA;
        begin
            ctl_t f;
            f = quiet(2'b00, m_c, m_z);
            f.fetch_en = 1'b1;
            f.pc_inc   = 1'b1;
            push(f, "ADDI:fetch");
        end
        tick();
        bus.instr = 4'hA;
        bus.alu_c = 1'b1;
        bus.alu_z = 1'b1;
        push(exec_ctl("ADDI", m_c, m_z), "ADDI:exec");
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        zero_ctl = quiet(2'b00, 1'b0, 1'b0);
        check_now("rst_abort_ctl", sample(), zero_ctl);
        @(posedge clock);
        #1;
        check_now("rst_abort_after_edge", sample(), zero_ctl);
        m_c    = 1'b0;
        m_z    = 1'b0;
        exp_pc = 12'h000;
        reset  = 1'b1;
        idle(2);

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            idle($urandom_range(2, 0));
            do_instr(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     12'($urandom));
        end
        idle(2);

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
